seq_restoring_div: RTL and testbench

- Sequential restoring divider. It is the inverse operation to the team's 4x4 Vedic multiplier.
- Takes an 8-bit product-width dividend and a 4-bit operand-width divisor. Returns an 8-bit quotient and a 4-bit remainder.
- Uses a start/busy/done handshake and retires one quotient bit per clock.
- Sits beside the multiplier in the arithmetic datapath, e.g. for product-check (a*b)/b == a.

---
 rtl/seq_restoring_div_pkg.sv | 15 +
 rtl/seq_restoring_div_sub_step.sv | 27 ++
 rtl/seq_restoring_div.sv | 112 +++++++++++
 tb/tb_seq_restoring_div.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/seq_restoring_div_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding,
// default widths and the iteration-counter width.
package seq_restoring_div_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int unsigned DEF_DW = 8;
    localparam int unsigned DEF_VW = 4;
    localparam int unsigned CW     = $clog2(DEF_DW);

endpackage

// File: rtl/seq_restoring_div_sub_step.sv
// One restoring step: W-bit ripple-borrow subtract built from full-adder cells
// (a + ~b + 1). no_borrow is the final carry, i.e. a >= b.
module div_sub_step #(
    parameter int unsigned W = 5
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-2:0] diff,
    output logic         no_borrow
);

    // The top difference bit is never needed: a kept difference is < b, whose MSB is 0.
    always_comb begin
        logic [W:0] c;
        c    = '0;
        c[0] = 1'b1;
        diff = '0;
        for (int unsigned i = 0; i < W; i++) begin
            if (i < W - 1) begin
                diff[i] = a[i] ^ ~b[i] ^ c[i];
            end
            c[i+1] = (a[i] & ~b[i]) | (a[i] & c[i]) | (~b[i] & c[i]);
        end
        no_borrow = c[W];
    end

endmodule

// File: rtl/seq_restoring_div.sv
// Sequential restoring divider, one quotient bit per clock, with a
// start/busy/done handshake and registered, held results.
module seq_restoring_div
    import seq_restoring_div_pkg::*;
#(
    parameter int unsigned DW = DEF_DW,
    parameter int unsigned VW = DEF_VW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);

    localparam int unsigned CNT_W = $clog2(DW);

    state_t         state;
    logic [DW-1:0]  q;
    logic [VW-1:0]  r;
    logic [VW-1:0]  d;
    logic [CNT_W-1:0] cnt;

    logic [VW:0]    t;
    logic [VW-1:0]  diff;
    logic           no_borrow;
    logic [VW-1:0]  r_nxt;
    logic [DW-1:0]  q_nxt;

    // Partial remainder is always < D after a step, so its (VW+1)-th bit is
    // provably zero and only the low VW bits are stored.
    assign t = {r, q[DW-1]};

    div_sub_step #(
        .W(VW + 1)
    ) u_step (
        .a         (t),
        .b         ({1'b0, d}),
        .diff      (diff),
        .no_borrow (no_borrow)
    );

    always_comb begin
        r_nxt = no_borrow ? diff : t[VW-1:0];
        q_nxt = {q[DW-2:0], no_borrow};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            q           <= '0;
            r           <= '0;
            d           <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        q    <= dividend;
                        d    <= divisor;
                        r    <= '0;
                        cnt  <= CNT_W'(DW - 1);
                        busy <= 1'b1;
                        if (divisor == '0) begin
                            state       <= S_DONE;
                            done        <= 1'b1;
                            quotient    <= '1;
                            remainder   <= dividend[VW-1:0];
                            div_by_zero <= 1'b1;
                        end else begin
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    q <= q_nxt;
                    r <= r_nxt;
                    if (cnt == '0) begin
                        state       <= S_DONE;
                        done        <= 1'b1;
                        quotient    <= q_nxt;
                        remainder   <= r_nxt;
                        div_by_zero <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_restoring_div.sv
// Directed and swept checks of seq_restoring_div against hand-computed results.
module tb_seq_restoring_div;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_restoring_div #(
        .DW(8),
        .VW(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Starts in an IDLE cycle, returns in the IDLE cycle after DONE.
    task automatic run_div(input string tag, input int a, input int b,
                           input int eq, input int er, input int ez, input int elat);
        int n;
        dividend = 8'(a);
        divisor  = 4'(b);
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        dividend = ~dividend;
        divisor  = ~divisor;
        n = 1;
        while (!done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq({tag, ".lat"}, n, elat);
        check_eq({tag, ".q"}, int'(quotient), eq);
        check_eq({tag, ".r"}, int'(remainder), er);
        check_eq({tag, ".dbz"}, int'(div_by_zero), ez);
        @(posedge clk); #1;
        check_eq({tag, ".pulse"}, int'(done), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int seen;
        rst      = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #1 rst = 1'b1;
        #1;
        check_eq("rst.busy", int'(busy), 0);
        check_eq("rst.done", int'(done), 0);
        check_eq("rst.q", int'(quotient), 0);
        check_eq("rst.r", int'(remainder), 0);
        check_eq("rst.dbz", int'(div_by_zero), 0);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;

        run_div("basic", 200, 7, 28, 4, 0, 9);
        run_div("c225_15", 225, 15, 15, 0, 0, 9);
        run_div("c5_9", 5, 9, 0, 5, 0, 9);
        run_div("c255_1", 255, 1, 255, 0, 0, 9);
        run_div("dbz", 'hA7, 0, 255, 7, 1, 1);
        run_div("after_dbz", 10, 3, 3, 1, 0, 9);

        // start re-pulsed while busy: in RUN and in the DONE cycle
        dividend = 8'd100;
        divisor  = 4'd6;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 1;
        while (!done && n < 40) begin
            if (n == 3) begin
                start    = 1'b1;
                dividend = 8'd9;
                divisor  = 4'd3;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        check_eq("busy.lat", n, 9);
        check_eq("busy.q", int'(quotient), 16);
        check_eq("busy.r", int'(remainder), 4);
        check_eq("busy.inrun", int'(busy), 1);
        start    = 1'b1;
        dividend = 8'd9;
        divisor  = 4'd3;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq("busy.single_done", int'(done), 0);
        check_eq("busy.idle", int'(busy), 0);
        check_eq("busy.q_held", int'(quotient), 16);
        run_div("busy_next", 9, 3, 3, 0, 0, 9);

        // asynchronous reset in the fourth RUN cycle
        dividend = 8'd200;
        divisor  = 4'd7;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check_eq("abort.busy", int'(busy), 0);
        check_eq("abort.done", int'(done), 0);
        check_eq("abort.q", int'(quotient), 0);
        check_eq("abort.r", int'(remainder), 0);
        check_eq("abort.dbz", int'(div_by_zero), 0);
        @(posedge clk); #1;
        rst  = 1'b0;
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        check_eq("abort.nodone", seen, 0);
        run_div("abort_after", 50, 5, 10, 0, 0, 9);

        for (int a = 0; a < 256; a++) begin
            for (int b = 1; b < 16; b++) begin
                run_div($sformatf("sw%0d_%0d", a, b), a, b, a / b, a % b, 0, 9);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
